mem_dump_uart: RTL

//   Post-run data-memory readout engine, attached downstream of the processor's external read port.
//   On a start pulse it walks an address window:
//     - drives each address onto the processor parallelAddress input;
//     - waits the fixed memory read latency, then captures the 8-bit q output;
//     - streams each captured byte off-chip as UART 8N1.

---
 rtl/dump_pkg.sv | 17 +
 rtl/mem_dump_uart_if.sv | 26 ++
 rtl/uart_tx.sv | 77 +++++++
 rtl/mem_dump_uart.sv | 116 +++++++++++
 4 files changed

// File: rtl/dump_pkg.sv
// Shared types and constants for the memory dump engine.
package dump_pkg;

   // Dump sequencer states
   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WAIT,
      SEND,
      TXW,
      FIN
   } state_e;

   // 50 MHz clock / 115200 baud
   localparam int CLKS_PER_BIT_DEF = 434;

endpackage

// File: rtl/mem_dump_uart_if.sv
// Host control, memory read port and serial line of the dump engine.
interface mem_dump_uart_if #(
   parameter int AW = 24,
   parameter int DW = 8
);
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] length;
   logic [AW-1:0] parallel_address;
   logic [DW-1:0] q;
   logic          tx;
   logic          busy;
   logic          done;

   // Environment side: host request plus the memory returning q
   modport master (
      output start, base_addr, length, q,
      input  parallel_address, tx, busy, done
   );

   // Dump engine side
   modport slave (
      input  start, base_addr, length, q,
      output parallel_address, tx, busy, done
   );
endinterface

// File: rtl/uart_tx.sv
// UART 8N1 transmitter: start bit, DW data bits LSB first, stop bit.
module uart_tx
   import dump_pkg::*;
#(
   parameter int DW           = 8,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tx_start,
   input  logic [DW-1:0] tx_data,
   output logic          tx,
   output logic          tx_busy,
   output logic          tx_done
);
   localparam int FRAME = DW + 2;
   localparam int BW    = $clog2(CLKS_PER_BIT);
   localparam int CW    = $clog2(FRAME);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(FRAME - 1);

   logic             active_q, active_d;
   logic [BW-1:0]    baud_q, baud_d;
   logic [CW-1:0]    bit_q, bit_d;
   logic [FRAME-1:0] shift_q, shift_d;
   logic             bit_end;

   // Idle line is high; an abort by reset drops active_q and releases the line at once
   assign bit_end = active_q && (baud_q == BAUD_LAST);
   assign tx      = active_q ? shift_q[0] : 1'b1;
   assign tx_busy = active_q;
   assign tx_done = bit_end && (bit_q == BIT_LAST);

   // Frame sequencing: load on tx_start, shift one bit every CLKS_PER_BIT cycles
   always_comb begin
      active_d = active_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      if (!active_q) begin
         if (tx_start) begin
            active_d = 1'b1;
            baud_d   = '0;
            bit_d    = '0;
            shift_d  = {1'b1, tx_data, 1'b0};
         end
      end else if (bit_end) begin
         baud_d  = '0;
         shift_d = {1'b1, shift_q[FRAME-1:1]};
         if (bit_q == BIT_LAST) begin
            active_d = 1'b0;
         end else begin
            bit_d = bit_q + 1'b1;
         end
      end else begin
         baud_d = baud_q + 1'b1;
      end
   end

   // Control state: cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         baud_q   <= '0;
         bit_q    <= '0;
      end else begin
         active_q <= active_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
      end
   end

   // Frame data: only observed while active_q is set, so it needs no reset
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end
endmodule

// File: rtl/mem_dump_uart.sv
// Walks an address window on the processor external read port and
// streams every returned byte out as UART 8N1.
module mem_dump_uart
   import dump_pkg::*;
#(
   parameter int AW           = 24,
   parameter int DW           = 8,
   parameter int READ_LAT     = 2,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   mem_dump_uart_if.slave  bus
);
   // The address register adds one cycle before the memory sees the new
   // address, so q is sampled READ_LAT cycles after parallel_address changes.
   localparam int LW = $clog2(READ_LAT + 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(READ_LAT);

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] rem_q, rem_d;
   logic [AW-1:0] pa_q, pa_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [DW-1:0] byte_q, byte_d;
   logic          tx_start, tx_busy, tx_done;

   assign bus.parallel_address = pa_q;
   assign bus.busy             = state_q inside {ADDR, WAIT, SEND, TXW};
   assign bus.done             = (state_q == FIN);

   // Sequencer next state and datapath updates
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      pa_d     = pa_q;
      lat_d    = lat_q;
      byte_d   = byte_q;
      tx_start = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               addr_d  = bus.base_addr;
               rem_d   = bus.length;
               state_d = (bus.length == '0) ? FIN : ADDR;
            end
         end
         ADDR: begin
            pa_d    = addr_q;
            lat_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (lat_q == LAT_LAST) begin
               byte_d  = bus.q;
               state_d = SEND;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         SEND: begin
            // The transmitter is always idle here; the guard keeps a stray
            // pulse from ever landing on a frame in flight.
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = TXW;
            end
         end
         TXW: begin
            if (tx_done) begin
               rem_d   = rem_q - 1'b1;
               addr_d  = addr_q + 1'b1;
               state_d = (rem_q == AW'(1)) ? FIN : ADDR;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control and address registers: cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         pa_q    <= '0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         pa_q    <= pa_d;
         lat_q   <= lat_d;
      end
   end

   // Captured byte: always rewritten before it is transmitted
   always_ff @(posedge clk) begin
      byte_q <= byte_d;
   end

   uart_tx #(
      .DW           (DW),
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx (
      .clk      (clk),
      .rst      (rst),
      .tx_start (tx_start),
      .tx_data  (byte_q),
      .tx       (bus.tx),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );
endmodule
